// File: rtl/game_pkg.sv
// Shared screen geometry, pixel/byte types and loader state encoding.
package game_pkg;

  localparam int SCREEN_WIDTH  = 1024;
  localparam int SCREEN_HEIGHT = 768;
  localparam int FRAME_PIXELS  = SCREEN_WIDTH * SCREEN_HEIGHT;

  typedef logic [7:0]  byte_t;
  typedef logic [11:0] pixel_t;   // {R[3:0], G[3:0], B[3:0]}

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_B0   = 3'd1;
  localparam state_t ST_B1   = 3'd2;
  localparam state_t ST_B2   = 3'd3;
  localparam state_t ST_CK0  = 3'd4;
  localparam state_t ST_CK1  = 3'd5;
  localparam state_t ST_DONE = 3'd6;

endpackage

// File: rtl/frame_loader_packer.sv
// Unpacks three stream bytes into two 12-bit pixels; pix_valid is combinational
// with the byte that completes a pixel.
module byte_to_pixel_packer
  import game_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear,
  input  logic   byte_valid,
  input  byte_t  byte_data,
  output logic   pix_valid,
  output pixel_t pix_data
);

  logic [1:0] phase_q, phase_d;
  byte_t      b0_q, b0_d;
  logic [3:0] b1_lo_q, b1_lo_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    phase_d   = phase_q;
    b0_d      = b0_q;
    b1_lo_d   = b1_lo_q;
    pix_valid = 1'b0;
    pix_data  = '0;
    if (clear) begin
      phase_d = 2'd0;
      b0_d    = '0;
      b1_lo_d = '0;
    end else if (byte_valid) begin
      case (phase_q)
        2'd0: begin
          b0_d    = byte_data;
          phase_d = 2'd1;
        end
        2'd1: begin
          pix_valid = 1'b1;
          pix_data  = {b0_q, byte_data[7:4]};
          b1_lo_d   = byte_data[3:0];
          phase_d   = 2'd2;
        end
        default: begin
          pix_valid = 1'b1;
          pix_data  = {b1_lo_q, byte_data};
          phase_d   = 2'd0;
        end
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 2'd0;
      b0_q    <= '0;
      b1_lo_q <= '0;
    end else begin
      phase_q <= phase_d;
      b0_q    <= b0_d;
      b1_lo_q <= b1_lo_d;
    end
  end

endmodule

// File: rtl/frame_loader.sv
// Writer side of the screen-image BRAM: packs a byte stream into pixels at y*W+x.
// Optional trailing 16-bit byte-sum checksum when FRAME_LOADER_CHECKSUM_EN is defined.
module frame_loader
  import game_pkg::*;
#(
  parameter int SCREEN_WIDTH  = game_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = game_pkg::SCREEN_HEIGHT,
  parameter int ADDR_WIDTH    = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [11:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  crc_err
);

  localparam longint NPIX = longint'(SCREEN_WIDTH) * longint'(SCREEN_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);

  if ((NPIX % 2) != 0 || (longint'(1) << ADDR_WIDTH) < NPIX) begin : g_bad_geometry
    $error("frame_loader: W*H must be even and fit in ADDR_WIDTH bits");
  end

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  pixel_t                wdata_q, wdata_d;

  logic   hs, start_go, byte_take, pix_valid;
  pixel_t pix_data;

  assign in_ready  = (state_q == ST_B0) || (state_q == ST_B1) || (state_q == ST_B2) ||
                     (state_q == ST_CK0) || (state_q == ST_CK1);
  assign hs        = in_valid && in_ready;
  assign start_go  = (state_q == ST_IDLE) && start && !abort;
  // Abort beats a simultaneous byte: the byte is handshaken but never reaches the packer.
  assign byte_take = hs && !abort &&
                     ((state_q == ST_B0) || (state_q == ST_B1) || (state_q == ST_B2));

  byte_to_pixel_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_go || abort),
    .byte_valid (byte_take),
    .byte_data  (in_data),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          state_d = ST_B0;
          cnt_d   = '0;
        end
        ST_B0: if (hs) state_d = ST_B1;
        ST_B1: if (hs) state_d = ST_B2;
        ST_B2: if (hs) begin
`ifdef FRAME_LOADER_CHECKSUM_EN
          state_d = (cnt_q == LAST_ADDR) ? ST_CK0 : ST_B0;
`else
          state_d = (cnt_q == LAST_ADDR) ? ST_DONE : ST_B0;
`endif
        end
`ifdef FRAME_LOADER_CHECKSUM_EN
        ST_CK0: if (hs) state_d = ST_CK1;
        ST_CK1: if (hs) state_d = ST_DONE;
`endif
        default: state_d = ST_IDLE;
      endcase
    end
    // The counter parks on the last address so a full 2^ADDR_WIDTH frame never wraps.
    if (pix_valid) begin
      we_d    = 1'b1;
      waddr_d = cnt_q;
      wdata_d = pix_data;
      if (cnt_q != LAST_ADDR) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);

`ifdef FRAME_LOADER_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
  logic [7:0]  ck_hi_q, ck_hi_d;
  logic        crc_err_q, crc_err_d;

  always_comb begin
    sum_d     = sum_q;
    ck_hi_d   = ck_hi_q;
    crc_err_d = crc_err_q;
    if (start_go) begin
      sum_d     = '0;
      crc_err_d = 1'b0;
    end else if (byte_take) begin
      sum_d = sum_q + 16'(in_data);
    end
    if (hs && !abort && state_q == ST_CK0) ck_hi_d = in_data;
    if (hs && !abort && state_q == ST_CK1) crc_err_d = ({ck_hi_q, in_data} != sum_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      ck_hi_q   <= '0;
      crc_err_q <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      ck_hi_q   <= ck_hi_d;
      crc_err_q <= crc_err_d;
    end
  end

  assign crc_err = crc_err_q;
`else
  assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader on a 4x2 frame; checksum cases when
// FRAME_LOADER_CHECKSUM_EN is defined.
module tb_frame_loader;
  import game_pkg::*;

  localparam int W = 4, H = 2, AW = 4, NPIX = 8, NBYTES = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready, mem_we, busy, done, crc_err;
  logic [AW-1:0] mem_waddr;
  logic [11:0]   mem_wdata;

  frame_loader #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .crc_err   (crc_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] wr_addr[$];
  logic [11:0]   wr_data[$];
  int            done_cnt = 0;
  int            done_busy = 0;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_waddr);
      wr_data.push_back(mem_wdata);
    end
    if (done) begin
      done_cnt++;
      if (busy) done_busy++;
    end
  end

  typedef struct {
    logic       st;
    logic       ab;
    logic       vld;
    logic [7:0] d;
    logic       e_we;
    logic [3:0] e_addr;
    logic [11:0] e_pix;
    logic       e_done;
    logic       e_busy;
    logic       e_rdy;
  } vec_t;

  vec_t        vecs[13];
  logic [7:0]  frame[NBYTES] = '{8'hAB, 8'hCD, 8'hEF, 8'h12, 8'h34, 8'h56,
                                 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h11};
  logic [11:0] exp_pix[NPIX] = '{12'hABC, 12'hDEF, 12'h123, 12'h456,
                                 12'h789, 12'hABC, 12'hDEF, 12'h011};
  logic [15:0] good_ck;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic st, input logic ab, input logic vld, input logic [7:0] d,
                              input logic we, input logic [3:0] a, input logic [11:0] px,
                              input logic dn, input logic bs, input logic rd);
    vec_t v;
    v.st = st; v.ab = ab; v.vld = vld; v.d = d;
    v.e_we = we; v.e_addr = a; v.e_pix = px;
    v.e_done = dn; v.e_busy = bs; v.e_rdy = rd;
    return v;
  endfunction

  // Compares writes logged since index base against the expected frame.
  task automatic check_log(input string tag, input int base);
    check({tag, "_nwrites"}, 32'(wr_addr.size() - base), 32'(NPIX));
    for (int i = 0; i < NPIX; i++) begin
      if (base + i < wr_addr.size()) begin
        check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[base+i]), 32'(i));
        check($sformatf("%s_data%0d", tag, i), 32'(wr_data[base+i]), 32'(exp_pix[i]));
      end
    end
  endtask

  // Loads the whole frame, optionally with random in_valid gaps, ending on the done cycle.
  task automatic run_frame(input string tag, input bit gaps, input logic [15:0] ck);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < NBYTES; i++) begin
      int unsigned g;
      g = gaps ? $urandom_range(0, 3) : 0;
      for (int k = 0; k < int'(g); k++) begin
        tick();
        check($sformatf("%s_gap_rdy%0d", tag, i), 32'(in_ready), 32'd1);
      end
      send(frame[i]);
    end
`ifdef FRAME_LOADER_CHECKSUM_EN
    send(ck[15:8]);
    send(ck[7:0]);
`endif
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int base, dbase;

    good_ck = '0;
    for (int i = 0; i < NBYTES; i++) good_ck = good_ck + 16'(frame[i]);

    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 12'h000, 1'b0, 1'b1, 1'b1);
    vecs[1]  = mk(1'b0, 1'b0, 1'b1, 8'hAB, 1'b0, 4'd0, 12'h000, 1'b0, 1'b1, 1'b1);
    vecs[2]  = mk(1'b0, 1'b0, 1'b1, 8'hCD, 1'b1, 4'd0, 12'hABC, 1'b0, 1'b1, 1'b1);
    vecs[3]  = mk(1'b0, 1'b0, 1'b1, 8'hEF, 1'b1, 4'd1, 12'hDEF, 1'b0, 1'b1, 1'b1);
    vecs[4]  = mk(1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 4'd0, 12'h000, 1'b0, 1'b1, 1'b1);
    vecs[5]  = mk(1'b0, 1'b0, 1'b1, 8'h34, 1'b1, 4'd2, 12'h123, 1'b0, 1'b1, 1'b1);
    vecs[6]  = mk(1'b0, 1'b0, 1'b1, 8'h56, 1'b1, 4'd3, 12'h456, 1'b0, 1'b1, 1'b1);
    vecs[7]  = mk(1'b1, 1'b0, 1'b1, 8'h78, 1'b0, 4'd0, 12'h000, 1'b0, 1'b1, 1'b1);
    vecs[8]  = mk(1'b0, 1'b0, 1'b1, 8'h9A, 1'b1, 4'd4, 12'h789, 1'b0, 1'b1, 1'b1);
    vecs[9]  = mk(1'b0, 1'b0, 1'b1, 8'hBC, 1'b1, 4'd5, 12'hABC, 1'b0, 1'b1, 1'b1);
    vecs[10] = mk(1'b0, 1'b0, 1'b1, 8'hDE, 1'b0, 4'd0, 12'h000, 1'b0, 1'b1, 1'b1);
    vecs[11] = mk(1'b0, 1'b0, 1'b1, 8'hF0, 1'b1, 4'd6, 12'hDEF, 1'b0, 1'b1, 1'b1);
`ifdef FRAME_LOADER_CHECKSUM_EN
    vecs[12] = mk(1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 4'd7, 12'h011, 1'b0, 1'b1, 1'b1);
`else
    vecs[12] = mk(1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 4'd7, 12'h011, 1'b1, 1'b0, 1'b0);
`endif

    // Reset state
    tick();
    tick();
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_waddr", 32'(mem_waddr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd0);
    check("rst_crc", 32'(crc_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Gap-free frame, cycle by cycle (row 7 also pulses start mid-load)
    base  = wr_addr.size();
    dbase = done_cnt;
    for (int i = 0; i < 13; i++) begin
      start    = vecs[i].st;
      abort    = vecs[i].ab;
      in_valid = vecs[i].vld;
      in_data  = vecs[i].d;
      tick();
      start    = 1'b0;
      abort    = 1'b0;
      in_valid = 1'b0;
      check($sformatf("v%0d_we", i), 32'(mem_we), 32'(vecs[i].e_we));
      if (vecs[i].e_we) begin
        check($sformatf("v%0d_addr", i), 32'(mem_waddr), 32'(vecs[i].e_addr));
        check($sformatf("v%0d_data", i), 32'(mem_wdata), 32'(vecs[i].e_pix));
      end
      check($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].e_done));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("v%0d_rdy", i), 32'(in_ready), 32'(vecs[i].e_rdy));
    end
`ifdef FRAME_LOADER_CHECKSUM_EN
    send(good_ck[15:8]);
    check("ck0_we", 32'(mem_we), 32'd0);
    check("ck0_busy", 32'(busy), 32'd1);
    send(good_ck[7:0]);
    check("ck1_done", 32'(done), 32'd1);
    check("ck1_busy", 32'(busy), 32'd0);
    check("ck1_crc_ok", 32'(crc_err), 32'd0);
`endif
    // Bytes offered after the frame must not produce a write to address 8
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick();
    check("post_idle_busy", 32'(busy), 32'd0);
    check("post_idle_rdy", 32'(in_ready), 32'd0);
    check("post_idle_done", 32'(done), 32'd0);
    tick();
    in_valid = 1'b0;
    tick();
    check_log("frame", base);
    check("frame_done_cnt", 32'(done_cnt - dbase), 32'd1);
    check("done_busy_overlap", 32'(done_busy), 32'd0);

    // Random in_valid gaps give the same writes
    base = wr_addr.size();
    run_frame("gaps", 1'b1, good_ck);
`ifdef FRAME_LOADER_CHECKSUM_EN
    check("gaps_crc_ok", 32'(crc_err), 32'd0);
`endif
    tick();
    tick();
    check_log("gaps", base);

    // Abort together with the third byte: only pix0 is written, no done
    base  = wr_addr.size();
    dbase = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    send(8'hAB);
    send(8'hCD);
    abort = 1'b1;
    send(8'hEF);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdy", 32'(in_ready), 32'd0);
    check("abort_we", 32'(mem_we), 32'd0);
    tick();
    tick();
    check("abort_nwrites", 32'(wr_addr.size() - base), 32'd1);
    if (wr_addr.size() > base) begin
      check("abort_addr", 32'(wr_addr[base]), 32'd0);
      check("abort_data", 32'(wr_data[base]), 32'hABC);
    end
    check("abort_no_done", 32'(done_cnt - dbase), 32'd0);

    // start and abort together in IDLE: stays idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    check("start_abort_rdy", 32'(in_ready), 32'd0);

    // Asynchronous reset mid-stream, then a fresh load starts at address 0
    start = 1'b1;
    tick();
    start = 1'b0;
    send(8'h12);
    send(8'h34);
    check("pre_rst_we", 32'(mem_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", 32'(mem_we), 32'd0);
    check("mid_rst_waddr", 32'(mem_waddr), 32'd0);
    check("mid_rst_wdata", 32'(mem_wdata), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    send(8'hAB);
    send(8'hCD);
    check("after_rst_we", 32'(mem_we), 32'd1);
    check("after_rst_addr", 32'(mem_waddr), 32'd0);
    check("after_rst_data", 32'(mem_wdata), 32'hABC);
    abort = 1'b1;
    tick();
    abort = 1'b0;

`ifdef FRAME_LOADER_CHECKSUM_EN
    // Checksum off by one: crc_err with done, held until the next start
    run_frame("badck", 1'b0, good_ck + 16'd1);
    check("badck_crc", 32'(crc_err), 32'd1);
    tick();
    check("badck_crc_hold", 32'(crc_err), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("badck_crc_clear", 32'(crc_err), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`else
    check("crc_tied_low", 32'(crc_err), 32'd0);
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
